// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing monitor: recovers coordinates from hsync/vsync, checks line/frame lengths, reports lock.
// Optional probe capture of the pixel colour at (probe_x, probe_y) when VGA_SYNC_PROBE_EN is defined.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        locked,
  output logic        frame_done,
  output logic        err_line,
  output logic        err_frame,
  output logic [11:0] probe_rgb,
  output logic        probe_valid
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] CMAX    = '1;
  localparam logic [CW-1:0] H_START = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_END   = CW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_START = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_END   = CW'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [CW:0]   H_LEN   = (CW+1)'(H_TOTAL);
  localparam logic [CW:0]   V_LEN   = (CW+1)'(V_TOTAL);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            hs_q;
  logic            vs_q;
  logic            hseen;
  logic            frame_line_err;
  logic [CW-1:0]   hcnt;
  logic [CW-1:0]   vcnt;
  logic [CW-1:0]   hcnt_nxt;
  logic [CW-1:0]   vcnt_nxt;
  logic            hs_fall_c;
  logic            vs_fall_c;
  logic            err_line_c;
  logic            err_frame_c;
  logic            locked_c;
  logic            video_on_c;
  logic            frame_done_c;
  logic [CW-1:0]   x_c;
  logic [CW-1:0]   y_c;

  // Edge detection, counter updates and length checks; checks use the pre-tick counts.
  always_comb begin
    hs_fall_c   = p_tick & hs_q & ~hsync;
    vs_fall_c   = p_tick & vs_q & ~vsync;
    hcnt_nxt    = hcnt;
    vcnt_nxt    = vcnt;
    if (hs_fall_c) begin
      hcnt_nxt = '0;
    end else if (hcnt != CMAX) begin
      hcnt_nxt = hcnt + CW'(1);
    end
    if (vs_fall_c) begin
      vcnt_nxt = '0;
    end else if (hs_fall_c && (vcnt != CMAX)) begin
      vcnt_nxt = vcnt + CW'(1);
    end
    err_line_c  = hs_fall_c & hseen & (state != S_SEARCH) &
                  (({1'b0, hcnt} + (CW+1)'(1)) != H_LEN);
    err_frame_c = vs_fall_c & (state != S_SEARCH) &
                  (({1'b0, vcnt} + (CW+1)'(1)) != V_LEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SEARCH: if (vs_fall_c) state_nxt = S_TRACK;
      S_TRACK: begin
        if (vs_fall_c && !frame_line_err && !err_line_c && !err_frame_c) begin
          state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (err_line_c) begin
          state_nxt = S_SEARCH;
        end else if (err_frame_c) begin
          state_nxt = S_TRACK;
        end
      end
      default: state_nxt = S_SEARCH;
    endcase
  end

  // Next output values describe the tick being sampled, using post-update counters.
  always_comb begin
    locked_c     = 1'b0;
    video_on_c   = 1'b0;
    x_c          = '0;
    y_c          = '0;
    frame_done_c = 1'b0;
    locked_c     = (state_nxt == S_LOCKED);
    video_on_c   = locked_c &&
                   (hcnt_nxt >= H_START) && (hcnt_nxt <= H_END) &&
                   (vcnt_nxt >= V_START) && (vcnt_nxt <= V_END);
    if (video_on_c) begin
      x_c = hcnt_nxt - H_START;
      y_c = vcnt_nxt - V_START;
    end
    frame_done_c = vs_fall_c & (state == S_LOCKED) & ~err_line_c & ~err_frame_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q           <= 1'b1;
      vs_q           <= 1'b1;
      hseen          <= 1'b0;
      frame_line_err <= 1'b0;
      hcnt           <= '0;
      vcnt           <= '0;
      x              <= '0;
      y              <= '0;
      video_on       <= 1'b0;
      locked         <= 1'b0;
      frame_done     <= 1'b0;
      err_line       <= 1'b0;
      err_frame      <= 1'b0;
    end else begin
      frame_done <= frame_done_c;
      err_line   <= err_line_c;
      err_frame  <= err_frame_c;
      if (p_tick) begin
        hs_q     <= hsync;
        vs_q     <= vsync;
        hseen    <= hseen | hs_fall_c;
        hcnt     <= hcnt_nxt;
        vcnt     <= vcnt_nxt;
        x        <= x_c;
        y        <= y_c;
        video_on <= video_on_c;
        locked   <= locked_c;
        // A frame only qualifies for lock if none of its lines were bad.
        if (vs_fall_c) begin
          frame_line_err <= 1'b0;
        end else if (err_line_c) begin
          frame_line_err <= 1'b1;
        end
      end
    end
  end

`ifdef VGA_SYNC_PROBE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
    end else begin
      probe_valid <= p_tick & video_on_c & (x_c == probe_x) & (y_c == probe_y);
      if (p_tick && video_on_c && (x_c == probe_x) && (y_c == probe_y)) begin
        probe_rgb <= rgb;
      end
    end
  end
`else
  logic unused_probe;
  assign unused_probe = ^{probe_x, probe_y, rgb};
  assign probe_rgb    = '0;
  assign probe_valid  = 1'b0;
`endif

endmodule
